// File: rtl/qs_insts_pkg.sv
// Shared instruction-set definitions for the quicksort engine: word types, opcodes,
// condition codes, field extractors and control-store symbol addresses.
package qs_insts_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_JCC  = 4'h1,
        OP_MOVI = 4'h2,
        OP_MOV  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_PUSH = 4'h8,
        OP_POP  = 4'h9,
        OP_CALL = 4'hC,
        OP_SYS  = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        CC_AL = 2'b00,
        CC_EQ = 2'b01,
        CC_GT = 2'b10,
        CC_LE = 2'b11
    } cc_e;

    typedef enum logic [1:0] {
        SEQ_RUN  = 2'd0,
        SEQ_WAIT = 2'd1,
        SEQ_TRAP = 2'd2
    } seq_state_e;

    localparam pc_t SYM_RESET = 8'd0;
    localparam pc_t SYM_START = 8'd32;
    localparam pc_t SYM_ERR   = 8'd128;

    function automatic logic [3:0] inst_opcode(inst_t i);
        return i[15:12];
    endfunction

    function automatic logic inst_sub(inst_t i);
        return i[11];
    endfunction

    function automatic cc_e inst_cc(inst_t i);
        return cc_e'(i[9:8]);
    endfunction

    function automatic pc_t inst_target(inst_t i);
        return i[7:0];
    endfunction

endpackage

// File: rtl/qs_ucode_dec.sv
// Combinational microcode decoder: classifies an instruction word as a locally
// resolved control-flow operation or one to be issued to the execute stage.
module qs_ucode_dec
    import qs_insts_pkg::*;
(
    input  inst_t word,
    output logic  is_jcc,
    output logic  is_call,
    output logic  is_ret,
    output logic  is_wait,
    output logic  is_emit,
    output logic  is_issue,
    output cc_e   cc,
    output pc_t   target
);

    // Bit 10 is reserved in every format.
    logic unused_bits;
    assign unused_bits = word[10];

    always_comb begin
        is_jcc   = 1'b0;
        is_call  = 1'b0;
        is_ret   = 1'b0;
        is_wait  = 1'b0;
        is_emit  = 1'b0;
        is_issue = 1'b0;
        cc       = inst_cc(word);
        target   = inst_target(word);
        case (inst_opcode(word))
            OP_JCC:  is_jcc = 1'b1;
            OP_CALL: begin
                if (inst_sub(word)) is_ret = 1'b1;
                else                is_call = 1'b1;
            end
            OP_SYS: begin
                if (inst_sub(word)) is_emit = 1'b1;
                else                is_wait = 1'b1;
            end
            default: is_issue = 1'b1;
        endcase
    end

endmodule

// File: rtl/qs_ucode_seq.sv
// Microcode sequencer: PC, link register, WAIT handling and one-entry issue slot.
// Optional error trap on fetch from SYM_ERR is enabled by QS_UCODE_ERR_TRAP_EN.
module qs_ucode_seq
    import qs_insts_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    output pc_t   rom_ra,
    input  inst_t rom_rout,
    output logic  inst_vld,
    output inst_t inst,
    input  logic  inst_rdy,
    input  logic  exe_busy,
    input  logic  flag_eq,
    input  logic  flag_gt,
    output pc_t   blink,
    input  logic  blink_wr_en,
    input  pc_t   blink_wr_data,
    input  logic  queue_ready,
    output logic  emit,
    output logic  err
);

    seq_state_e state_q, state_d;
    pc_t        pc_q, pc_d, pc_inc;
    pc_t        blink_q, blink_d;
    logic       slot_vld_q, slot_vld_d;
    inst_t      slot_q, slot_d;
    logic       emit_q, emit_d;

    logic is_jcc, is_call, is_ret, is_wait, is_emit, is_issue;
    cc_e  cc;
    pc_t  target;

    logic issue_stall, drained, cond_taken, call_fire, issue_fire, trap_hit;

    qs_ucode_dec u_dec (
        .word     (rom_rout),
        .is_jcc   (is_jcc),
        .is_call  (is_call),
        .is_ret   (is_ret),
        .is_wait  (is_wait),
        .is_emit  (is_emit),
        .is_issue (is_issue),
        .cc       (cc),
        .target   (target)
    );

`ifdef QS_UCODE_ERR_TRAP_EN
    assign trap_hit = (state_q == SEQ_RUN) && (pc_q == SYM_ERR);
    assign err      = (state_q == SEQ_TRAP);
`else
    assign trap_hit = 1'b0;
    assign err      = 1'b0;
`endif

    assign issue_stall = slot_vld_q && !inst_rdy;
    assign drained     = !slot_vld_q && !exe_busy;
    assign pc_inc      = pc_q + pc_t'(1);

    always_comb begin
        case (cc)
            CC_AL:   cond_taken = 1'b1;
            CC_EQ:   cond_taken = flag_eq;
            CC_GT:   cond_taken = flag_gt;
            default: cond_taken = !flag_gt;
        endcase
    end

    // Control-flow resolution: anything that reads flags or BLINK, or signals
    // completion, waits for the execute side to go quiet first.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        emit_d     = 1'b0;
        call_fire  = 1'b0;
        issue_fire = 1'b0;
        case (state_q)
            SEQ_RUN: begin
                if (trap_hit) begin
                    state_d = SEQ_TRAP;
                end else if (!issue_stall) begin
                    if (is_jcc) begin
                        if (cc == CC_AL)  pc_d = target;
                        else if (drained) pc_d = cond_taken ? target : pc_inc;
                    end else if (is_call) begin
                        if (drained) begin
                            call_fire = 1'b1;
                            pc_d      = target;
                        end
                    end else if (is_ret) begin
                        if (drained) pc_d = blink_q;
                    end else if (is_wait) begin
                        if (queue_ready) pc_d = pc_inc;
                        else             state_d = SEQ_WAIT;
                    end else if (is_emit) begin
                        if (drained) begin
                            emit_d = 1'b1;
                            pc_d   = pc_inc;
                        end
                    end else if (is_issue) begin
                        issue_fire = 1'b1;
                        pc_d       = pc_inc;
                    end
                end
            end
            SEQ_WAIT: begin
                if (!issue_stall && queue_ready) begin
                    state_d = SEQ_RUN;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // CALL takes priority over a coincident POP BLINK writeback.
    always_comb begin
        blink_d = blink_q;
        if (call_fire)        blink_d = pc_inc;
        else if (blink_wr_en) blink_d = blink_wr_data;
    end

    always_comb begin
        slot_vld_d = issue_fire || (slot_vld_q && !inst_rdy);
        slot_d     = issue_fire ? rom_rout : slot_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_RUN;
            pc_q       <= SYM_RESET;
            blink_q    <= '0;
            slot_vld_q <= 1'b0;
            slot_q     <= '0;
            emit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            blink_q    <= blink_d;
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
            emit_q     <= emit_d;
        end
    end

    assign rom_ra   = pc_q;
    assign inst_vld = slot_vld_q;
    assign inst     = slot_q;
    assign blink    = blink_q;
    assign emit     = emit_q;

endmodule

// File: tb/tb_qs_ucode_seq.sv
// Bench for qs_ucode_seq: directed walk through a small control-store program plus a
// randomized run checked against a queue-based sequencer model.
module tb_qs_ucode_seq;
    import qs_insts_pkg::*;

`ifdef QS_UCODE_ERR_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    pc_t   rom_ra;
    inst_t rom_rout;
    logic  inst_vld;
    inst_t inst;
    logic  inst_rdy = 1'b1;
    logic  exe_busy = 1'b0;
    logic  flag_eq = 1'b0;
    logic  flag_gt = 1'b0;
    pc_t   blink;
    logic  blink_wr_en = 1'b0;
    pc_t   blink_wr_data = '0;
    logic  queue_ready = 1'b0;
    logic  emit;
    logic  err;

    inst_t rom [0:255];
    assign rom_rout = rom[rom_ra];

    int checks = 0;
    int passed = 0;

    pc_t   m_pc;
    pc_t   m_blink;
    inst_t m_slot[$];
    bit    m_wait;
    bit    m_trap;
    bit    m_emit;

    always #5 clk = ~clk;

    qs_ucode_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_ra        (rom_ra),
        .rom_rout      (rom_rout),
        .inst_vld      (inst_vld),
        .inst          (inst),
        .inst_rdy      (inst_rdy),
        .exe_busy      (exe_busy),
        .flag_eq       (flag_eq),
        .flag_gt       (flag_gt),
        .blink         (blink),
        .blink_wr_en   (blink_wr_en),
        .blink_wr_data (blink_wr_data),
        .queue_ready   (queue_ready),
        .emit          (emit),
        .err           (err)
    );

    task automatic load_rom();
        for (int a = 0; a < 256; a++) rom[a] = 16'h1080;
        rom[0]  = 16'h1020;
        rom[32] = 16'hF000;
        rom[33] = 16'h2000;
        rom[34] = 16'h5800;
        rom[35] = 16'hC060;
        rom[36] = 16'hF800;
        rom[37] = 16'h1020;
        rom[70] = 16'h5812;
        rom[71] = 16'h1251;
        rom[72] = 16'h0000;
        rom[73] = 16'h114B;
        rom[74] = 16'h2777;
        rom[75] = 16'h1350;
        rom[80] = 16'hC800;
        rom[81] = 16'h7000;
        rom[82] = 16'h1050;
        rom[96] = 16'h2105;
        rom[97] = 16'h1046;
    endtask

    task automatic m_reset();
        m_pc    = 8'd0;
        m_blink = 8'd0;
        m_slot.delete();
        m_wait  = 1'b0;
        m_trap  = 1'b0;
        m_emit  = 1'b0;
    endtask

    task automatic set_defaults();
        inst_rdy    = 1'b1;
        exe_busy    = 1'b0;
        flag_eq     = 1'b0;
        flag_gt     = 1'b0;
        blink_wr_en = 1'b0;
        queue_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_defaults();
        @(posedge clk);
        #1;
        m_reset();
        rst_n = 1'b1;
    endtask

    // Advance one clock; the model works out the next architectural state from the
    // instruction at its own PC and the inputs held across the edge.
    task automatic tick();
        inst_t w;
        pc_t   nxt_pc, nxt_blink, pc_plus;
        bit    nxt_wait, nxt_trap, nxt_emit, push_w, pop_w, has_slot, blocked, quiet, call_done, take;
        w         = rom[m_pc];
        pc_plus   = m_pc + 8'd1;
        nxt_pc    = m_pc;
        nxt_blink = m_blink;
        nxt_wait  = m_wait;
        nxt_trap  = m_trap;
        nxt_emit  = 1'b0;
        push_w    = 1'b0;
        call_done = 1'b0;
        has_slot  = (m_slot.size() != 0);
        pop_w     = has_slot && inst_rdy;
        blocked   = has_slot && !inst_rdy;
        quiet     = !has_slot && !exe_busy;
        case (w[9:8])
            2'd0:    take = 1'b1;
            2'd1:    take = flag_eq;
            2'd2:    take = flag_gt;
            default: take = !flag_gt;
        endcase
        if (m_trap) begin
            nxt_trap = 1'b1;
        end else if (TRAP_EN && m_pc == 8'd128) begin
            nxt_trap = 1'b1;
        end else if (blocked) begin
            nxt_pc = m_pc;
        end else if (m_wait) begin
            if (queue_ready) begin
                nxt_wait = 1'b0;
                nxt_pc   = pc_plus;
            end
        end else begin
            case (w[15:12])
                4'h1: begin
                    if (w[9:8] == 2'b00 || quiet) nxt_pc = take ? w[7:0] : pc_plus;
                end
                4'hC: begin
                    if (quiet && w[11]) nxt_pc = m_blink;
                    if (quiet && !w[11]) begin
                        call_done = 1'b1;
                        nxt_blink = pc_plus;
                        nxt_pc    = w[7:0];
                    end
                end
                4'hF: begin
                    if (w[11] && quiet) begin
                        nxt_emit = 1'b1;
                        nxt_pc   = pc_plus;
                    end
                    if (!w[11] && queue_ready) nxt_pc = pc_plus;
                    if (!w[11] && !queue_ready) nxt_wait = 1'b1;
                end
                default: begin
                    push_w = 1'b1;
                    nxt_pc = pc_plus;
                end
            endcase
        end
        if (blink_wr_en && !call_done) nxt_blink = blink_wr_data;
        @(posedge clk);
        #1;
        m_pc    = nxt_pc;
        m_blink = nxt_blink;
        m_wait  = nxt_wait;
        m_trap  = nxt_trap;
        m_emit  = nxt_emit;
        if (pop_w) void'(m_slot.pop_front());
        if (push_w) m_slot.push_back(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_defaults();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rom_ra !== 8'd0) $display("[TB] FAIL reset_rom_ra: got %0d expected 0", rom_ra); else passed++;
        checks++; if (inst_vld !== 1'b0) $display("[TB] FAIL reset_inst_vld: got %b expected 0", inst_vld); else passed++;
        checks++; if (inst !== 16'h0000) $display("[TB] FAIL reset_inst: got %h expected 0000", inst); else passed++;
        checks++; if (blink !== 8'd0) $display("[TB] FAIL reset_blink: got %0d expected 0", blink); else passed++;
        checks++; if (emit !== 1'b0 || err !== 1'b0) $display("[TB] FAIL reset_emit_err: got %b%b expected 00", emit, err); else passed++;
        m_reset();
        rst_n = 1'b1;
        tick();
        checks++; if (rom_ra !== 8'd32) $display("[TB] FAIL reset_vector_jump: got %0d expected 32", rom_ra); else passed++;
        checks++; if (inst_vld !== 1'b0) $display("[TB] FAIL reset_no_issue: got %b expected 0", inst_vld); else passed++;
    endtask

    task automatic test_wait();
        queue_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rom_ra !== 8'd32) $display("[TB] FAIL wait_hold[%0d]: got %0d expected 32", i, rom_ra); else passed++;
        end
        queue_ready = 1'b1;
        tick();
        checks++; if (rom_ra !== 8'd33) $display("[TB] FAIL wait_release: got %0d expected 33", rom_ra); else passed++;
        queue_ready = 1'b0;
        tick();
        checks++; if (inst_vld !== 1'b1 || inst !== 16'h2000) $display("[TB] FAIL wait_movi_issue: got vld=%b inst=%h expected vld=1 inst=2000", inst_vld, inst); else passed++;
        checks++; if (rom_ra !== 8'd34) $display("[TB] FAIL wait_next_fetch: got %0d expected 34", rom_ra); else passed++;
    endtask

    task automatic test_call();
        tick();
        checks++; if (rom_ra !== 8'd35 || inst !== 16'h5800) $display("[TB] FAIL call_setup: got ra=%0d inst=%h expected ra=35 inst=5800", rom_ra, inst); else passed++;
        for (int i = 0; i < 8 && rom_ra == 8'd35; i++) tick();
        checks++; if (rom_ra !== 8'd96) $display("[TB] FAIL call_target: got %0d expected 96", rom_ra); else passed++;
        checks++; if (blink !== 8'd36) $display("[TB] FAIL call_blink: got %0d expected 36", blink); else passed++;
    endtask

    task automatic test_jgt_taken();
        tick();
        tick();
        tick();
        checks++; if (rom_ra !== 8'd71) $display("[TB] FAIL jgt_reach: got %0d expected 71", rom_ra); else passed++;
        exe_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rom_ra !== 8'd71) $display("[TB] FAIL jgt_drain_hold[%0d]: got %0d expected 71", i, rom_ra); else passed++;
        end
        exe_busy = 1'b0;
        flag_gt  = 1'b1;
        tick();
        checks++; if (rom_ra !== 8'd81) $display("[TB] FAIL jgt_taken: got %0d expected 81", rom_ra); else passed++;
        flag_gt = 1'b0;
    endtask

    task automatic test_ret();
        for (int i = 0; i < 10 && rom_ra != 8'd80; i++) tick();
        tick();
        checks++; if (rom_ra !== 8'd36) $display("[TB] FAIL ret_target: got %0d expected 36", rom_ra); else passed++;
    endtask

    task automatic test_emit();
        exe_busy = 1'b1;
        tick();
        checks++; if (rom_ra !== 8'd36 || emit !== 1'b0) $display("[TB] FAIL emit_drain: got ra=%0d emit=%b expected ra=36 emit=0", rom_ra, emit); else passed++;
        exe_busy = 1'b0;
        tick();
        checks++; if (rom_ra !== 8'd37 || emit !== 1'b1) $display("[TB] FAIL emit_pulse: got ra=%0d emit=%b expected ra=37 emit=1", rom_ra, emit); else passed++;
        tick();
        checks++; if (rom_ra !== 8'd32 || emit !== 1'b0) $display("[TB] FAIL emit_end: got ra=%0d emit=%b expected ra=32 emit=0", rom_ra, emit); else passed++;
    endtask

    task automatic test_issue_stall();
        queue_ready = 1'b1;
        tick();
        queue_ready = 1'b0;
        inst_rdy    = 1'b0;
        tick();
        checks++; if (rom_ra !== 8'd34 || inst !== 16'h2000 || inst_vld !== 1'b1) $display("[TB] FAIL stall_fill: got ra=%0d inst=%h vld=%b expected 34 2000 1", rom_ra, inst, inst_vld); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rom_ra !== 8'd34 || inst !== 16'h2000) $display("[TB] FAIL stall_hold[%0d]: got ra=%0d inst=%h expected 34 2000", i, rom_ra, inst); else passed++;
        end
        inst_rdy = 1'b1;
        tick();
        checks++; if (rom_ra !== 8'd35 || inst !== 16'h5800 || inst_vld !== 1'b1) $display("[TB] FAIL stall_resume: got ra=%0d inst=%h vld=%b expected 35 5800 1", rom_ra, inst, inst_vld); else passed++;
    endtask

    task automatic test_jgt_not_taken();
        for (int i = 0; i < 20 && rom_ra != 8'd71; i++) tick();
        flag_gt = 1'b0;
        for (int i = 0; i < 8 && rom_ra == 8'd71; i++) tick();
        checks++; if (rom_ra !== 8'd72) $display("[TB] FAIL jgt_not_taken: got %0d expected 72", rom_ra); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        rom[37]  = 16'h10FE;
        rom[254] = 16'h0000;
        rom[255] = 16'h0000;
        queue_ready = 1'b1;
        for (int i = 0; i < 80 && rom_ra != 8'd254; i++) tick();
        checks++; if (rom_ra !== 8'd254) $display("[TB] FAIL wrap_reach: got %0d expected 254", rom_ra); else passed++;
        tick();
        tick();
        checks++; if (rom_ra !== 8'd0) $display("[TB] FAIL wrap_zero: got %0d expected 0", rom_ra); else passed++;
        tick();
        checks++; if (rom_ra !== 8'd32) $display("[TB] FAIL wrap_vector: got %0d expected 32", rom_ra); else passed++;
        rom[37] = 16'h1020;
    endtask

    task automatic test_err();
        do_reset();
        rom[37] = 16'h10C8;
        queue_ready = 1'b1;
        for (int i = 0; i < 80 && rom_ra != 8'd200; i++) tick();
        tick();
        checks++; if (rom_ra !== SYM_ERR) $display("[TB] FAIL err_vector: got %0d expected 128", rom_ra); else passed++;
        repeat (3) tick();
        checks++; if (rom_ra !== SYM_ERR) $display("[TB] FAIL err_hold: got %0d expected 128", rom_ra); else passed++;
        checks++; if (err !== TRAP_EN) $display("[TB] FAIL err_flag: got %b expected %b", err, TRAP_EN); else passed++;
        checks++; if (inst_vld !== 1'b0) $display("[TB] FAIL err_no_issue: got %b expected 0", inst_vld); else passed++;
        rom[37] = 16'h1020;
    endtask

    task automatic test_random();
        pc_t links [3] = '{8'd36, 8'd33, 8'd72};
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            inst_rdy      = ($urandom_range(0, 3) != 0);
            exe_busy      = ($urandom_range(0, 3) == 0);
            flag_eq       = 1'($urandom_range(0, 1));
            flag_gt       = 1'($urandom_range(0, 1));
            queue_ready   = ($urandom_range(0, 2) == 0);
            blink_wr_en   = ($urandom_range(0, 15) == 0);
            blink_wr_data = links[$urandom_range(0, 2)];
            tick();
            checks++; if (rom_ra !== m_pc) $display("[TB] FAIL rand_rom_ra cyc %0d: got %0d expected %0d", cyc, rom_ra, m_pc); else passed++;
            checks++; if (inst_vld !== (m_slot.size() != 0)) $display("[TB] FAIL rand_inst_vld cyc %0d: got %b expected %b", cyc, inst_vld, m_slot.size() != 0); else passed++;
            if (m_slot.size() != 0) begin
                checks++; if (inst !== m_slot[0]) $display("[TB] FAIL rand_inst cyc %0d: got %h expected %h", cyc, inst, m_slot[0]); else passed++;
            end
            checks++; if (blink !== m_blink) $display("[TB] FAIL rand_blink cyc %0d: got %0d expected %0d", cyc, blink, m_blink); else passed++;
            checks++; if (emit !== m_emit) $display("[TB] FAIL rand_emit cyc %0d: got %b expected %b", cyc, emit, m_emit); else passed++;
            checks++; if (err !== m_trap) $display("[TB] FAIL rand_err cyc %0d: got %b expected %b", cyc, err, m_trap); else passed++;
        end
        set_defaults();
    endtask

    initial begin
        load_rom();
        m_reset();
        test_reset();
        test_wait();
        test_call();
        test_jgt_taken();
        test_ret();
        test_emit();
        test_issue_stall();
        test_jgt_not_taken();
        test_wrap();
        test_err();
        test_random();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/qs_ucode_seq.md
# qs_ucode_seq

Microcode sequencer for the quicksort engine. It owns the program counter and drives the control-store address, then consumes the returned instruction word. Control-flow instructions (J/Jcc, CALL, RET, WAIT, EMIT) are resolved locally. All other instructions are handed to the execute stage through a one-entry valid/ready issue slot.

## Interface
Parameters:
- none; `pc_t`, `inst_t` and the symbol addresses come from the shared package.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `rom_ra`  out  `pc_t`  control-store address (registered PC)
- `rom_rout`  in  `inst_t`  instruction at `rom_ra`, same cycle (combinational store)
- `inst_vld`  out  1  issue slot holds an instruction
- `inst`  out  `inst_t`  issued instruction
- `inst_rdy`  in  1  execute accepts `inst` this cycle
- `exe_busy`  in  1  execute has an instruction in flight (flags/BLINK/memory not settled)
- `flag_eq`, `flag_gt`  in  1 each  flags from the last `SUB.F`
- `blink`  out  `pc_t`  link register (for `PUSH BLINK`)
- `blink_wr_en`, `blink_wr_data`  in  1 / `pc_t`  `POP BLINK` writeback
- `queue_ready`  in  1  input data loaded; releases WAIT
- `emit`  out  1  one-cycle pulse: sort complete
- `err`  out  1  sticky error trap (see Configuration)

## Operation
- Decode fields: opcode [15:12]; sub-bit [11]; cc [9:8]; target [7:0].
- Jcc (`0001`):
  - cc=00 always taken.
  - EQ is taken when `flag_eq`.
  - GT is taken when `flag_gt`.
  - LE is taken when `!flag_gt`.
  - Taken: PC ← target. Not taken: PC ← PC+1.
- CALL (`1100`, [11]=0): `blink` ← PC+1; PC ← target.
- RET (`1100`, [11]=1): PC ← `blink`.
- WAIT (`1111`, [11]=0): hold PC while `queue_ready`=0. Advance in the cycle it samples 1.
- EMIT (`1111`, [11]=1): pulse `emit` for one cycle; PC ← PC+1.
- All other opcodes, including NOP, are issued: slot ← `rom_rout`; PC ← PC+1.
- Issue stall: if the slot is valid and `inst_rdy`=0, PC, slot and `inst` hold stable.
- Drain stall: unconditional J never stalls. Conditional Jcc, CALL, RET and EMIT stall until the slot is empty and `exe_busy`=0.
- States:
  - RUN: normal fetch.
  - WAIT: entered on WAIT with `queue_ready`=0; returns to RUN, PC+1, when `queue_ready`=1.
  - TRAP: macro only; terminal until reset.
- PC arithmetic is modulo 2^width of `pc_t`. PC+1 at the top address wraps to 0, which fetches the reset vector.
- Simultaneous `blink_wr_en` and CALL cannot occur because of the drain stall. If they do coincide, CALL wins.

## Timing
- Reset values:
  - `rom_ra`=SYM_RESET (0)
  - `blink`=0
  - `inst_vld`=0, `inst`=0
  - `emit`=0, `err`=0
  - state RUN
- Reset mid-operation discards the slot and any stall immediately (asynchronous).
- One instruction is fetched per cycle with no stalls. Taken branches, CALL and RET cost zero bubble cycles beyond any drain stall.
- Issue latency: an instruction at `rom_ra` in cycle N appears on `inst` with `inst_vld`=1 in cycle N+1.
- The slot is written in the same cycle it drains (`inst_vld` && `inst_rdy`), giving full throughput.
- `emit` is asserted in the cycle after EMIT is resolved, for exactly one cycle.
- `flag_*` and `blink` are sampled only in the resolving cycle, which is after the drain stall ends.

## Configuration
- `QS_UCODE_ERR_TRAP_EN` defined:
  - A fetch from SYM_ERR sets `err` sticky.
  - State goes to TRAP; PC freezes and no further issue occurs.
  - `err` stays set until reset.
- `QS_UCODE_ERR_TRAP_EN` undefined:
  - `err` is tied 0.
  - SYM_ERR executes as an ordinary self-jump.

## Structure
- The shared `qs_insts_pkg` holds the following, and the control store uses the same definitions:
  - `pc_t`, `inst_t`
  - opcode and cc enums
  - field-extract functions
  - SYM_RESET/SYM_START/SYM_ERR
- Natural sub-module: `qs_ucode_dec`. It is purely combinational: `inst_t` in; is_jcc/is_call/is_ret/is_wait/is_emit/is_issue, cc and target out.
- Sequencer FSM, PC, BLINK and issue slot live in `qs_ucode_seq`.

## Test plan
- Reset release with the real ROM:
  - Cycle 0: `rom_ra`=0.
  - Cycle 1: `rom_ra`=32.
  - `inst_vld`=0 throughout.
- WAIT at 32 with `queue_ready`=0 for 5 cycles: `rom_ra` stays 32. Raise it: next cycle `rom_ra`=33; the cycle after, MOVI R0,0 is issued.
- CALL 96 at 35:
  - `blink`=36, `rom_ra`=96.
  - Later RET with `exe_busy`=0: `rom_ra`=36.
- JGT at 71 (target 81):
  - Hold `exe_busy`=1 for 3 cycles: `rom_ra` stays 71.
  - Then `flag_gt`=1 gives `rom_ra`=81; `flag_gt`=0 gives `rom_ra`=72.
- `inst_rdy`=0 for 4 cycles with the slot full: `inst` stays constant and `rom_ra` stays constant. Release: one issue per cycle resumes.
- EMIT at 36 after drain: `emit` high for exactly 1 cycle. Then `rom_ra`=37, then 32.
- With `QS_UCODE_ERR_TRAP_EN`: force an unmapped address (200 → SYM_ERR). `err`=1, `inst_vld`=0, and `rom_ra`=128 is held.
